// File: rtl/thor2022_insalign_if.sv
// Fetch-side and instruction-side handshake bundle for the instruction aligner.
interface thor2022_insalign_if #(
  parameter int AWID = 32
);
  logic            flush_i;
  logic [AWID-1:0] flush_pc_i;
  logic [63:0]     fw_i;
  logic            fw_valid_i;
  logic            fw_ready_o;
  logic [7:0]      ilen_op_o;
  logic [3:0]      ilen_i;
  logic [63:0]     ins_o;
  logic [3:0]      ins_len_o;
  logic [AWID-1:0] ins_pc_o;
  logic            ins_valid_o;
  logic            ins_ready_i;

  // Aligner side
  modport slave (
    input  flush_i, flush_pc_i, fw_i, fw_valid_i, ilen_i, ins_ready_i,
    output fw_ready_o, ilen_op_o, ins_o, ins_len_o, ins_pc_o, ins_valid_o
  );

  // Fetch unit / decoder side
  modport master (
    output flush_i, flush_pc_i, fw_i, fw_valid_i, ilen_i, ins_ready_i,
    input  fw_ready_o, ilen_op_o, ins_o, ins_len_o, ins_pc_o, ins_valid_o
  );
endinterface

// File: rtl/thor2022_insalign.sv
// Instruction aligner: turns 8-byte aligned fetch words into variable-length
// (2/4/6/8 byte) instructions using a 16-byte shift buffer.
module thor2022_insalign #(
  parameter int AWID = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  thor2022_insalign_if.slave    bus
);

  logic [127:0]    bq_q, bq_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [AWID-1:0] pc_q, pc_d;
  logic [2:0]      skip_q, skip_d;

  logic [3:0]      len;
  logic            valid;
  logic            issue;
  logic            fw_ready;
  logic            accept;
  logic [63:0]     ins_c;

  logic [127:0]    post_bq;
  logic [4:0]      post_cnt;
  logic [63:0]     fw_trim;
  logic [127:0]    fw_app;

  // Effective length: anything the decoder returns outside {2,4,6,8} is treated as 2
  always_comb begin
    case (bus.ilen_i)
      4'd2, 4'd4, 4'd6, 4'd8: len = bus.ilen_i;
      default:                len = 4'd2;
    endcase
  end

  // Handshake qualifiers; fw_ready depends only on registered count and flush
  always_comb begin
    valid    = !bus.flush_i && (cnt_q >= 5'd2) && (cnt_q >= {1'b0, len});
    issue    = valid && bus.ins_ready_i;
    fw_ready = !bus.flush_i && (cnt_q <= 5'd8);
    accept   = bus.fw_valid_i && fw_ready;
  end

  // Instruction output: low L buffer bytes, upper bytes forced to zero
  always_comb begin
    ins_c = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < 32'(len)) ins_c[i*8 +: 8] = bq_q[i*8 +: 8];
    end
  end

  // Output drive; length reads as 2 while reset is held regardless of the decoder
  always_comb begin
    bus.ilen_op_o   = bq_q[7:0];
    bus.ins_o       = ins_c;
    bus.ins_len_o   = rst_i ? 4'd2 : len;
    bus.ins_pc_o    = pc_q;
    bus.ins_valid_o = valid;
    bus.fw_ready_o  = fw_ready;
  end

  // Next-state: issue shifts first, then the trimmed fetch word is appended
  // behind the post-issue contents. Bytes at and above count are kept zero so
  // the append can be a plain OR.
  always_comb begin
    post_bq  = issue ? (bq_q >> {len, 3'b000}) : bq_q;
    post_cnt = issue ? (cnt_q - {1'b0, len}) : cnt_q;
    fw_trim  = bus.fw_i >> {skip_q, 3'b000};
    fw_app   = {64'd0, fw_trim} << {post_cnt, 3'b000};

    bq_d   = post_bq;
    cnt_d  = post_cnt;
    pc_d   = issue ? (pc_q + AWID'(len)) : pc_q;
    skip_d = skip_q;

    if (bus.flush_i) begin
      bq_d   = '0;
      cnt_d  = '0;
      pc_d   = bus.flush_pc_i;
      skip_d = bus.flush_pc_i[2:0];
    end else if (accept) begin
      bq_d   = post_bq | fw_app;
      cnt_d  = post_cnt + (5'd8 - {2'b00, skip_q});
      skip_d = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bq_q   <= '0;
      cnt_q  <= '0;
      pc_q   <= '0;
      skip_q <= '0;
    end else begin
      bq_q   <= bq_d;
      cnt_q  <= cnt_d;
      pc_q   <= pc_d;
      skip_q <= skip_d;
    end
  end

endmodule

// File: tb/tb_thor2022_insalign.sv
// Self-checking bench for thor2022_insalign: table of stream scenarios checked
// through a byte-stream scoreboard, plus hand sequences for backpressure,
// flush collision and asynchronous reset.
module tb_thor2022_insalign;

  localparam int AWID = 32;

  logic clk;
  logic rst;

  thor2022_insalign_if #(.AWID(AWID)) bus ();

  thor2022_insalign #(.AWID(AWID)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External length decoder model
  logic [3:0] lentab [256];
  always_comb bus.ilen_i = lentab[bus.ilen_op_o];

  typedef struct {
    logic [63:0]     ins;
    logic [3:0]      len;
    logic [AWID-1:0] pc;
  } exp_t;

  typedef struct {
    logic [AWID-1:0] fpc;
    logic [63:0]     w0;
    logic [63:0]     w1;
    int              nw;
    logic [63:0]     first_ins;
    logic [3:0]      first_len;
    logic [AWID-1:0] final_pc;
  } vec_t;

  exp_t            sbq [$];
  logic [7:0]      mb  [$];
  logic [AWID-1:0] mpc;
  logic [2:0]      mskip;

  int checks = 0;
  int errors = 0;
  bit rmode = 1'b0;
  bit acc;
  bit first_seen;
  logic [63:0] first_ins;
  logic [3:0]  first_len;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] eff(input logic [3:0] l);
    return (l == 4'd2 || l == 4'd4 || l == 4'd6 || l == 4'd8) ? l : 4'd2;
  endfunction

  function automatic void model_gen();
    exp_t e;
    logic [3:0] l;
    while (mb.size() > 0) begin
      l = eff(lentab[mb[0]]);
      if (mb.size() < int'(l)) break;
      e.ins = '0;
      for (int i = 0; i < int'(l); i++) e.ins[i*8 +: 8] = mb.pop_front();
      e.len = l;
      e.pc  = mpc;
      mpc   = mpc + AWID'(l);
      sbq.push_back(e);
    end
  endfunction

  function automatic void model_flush(input logic [AWID-1:0] pc);
    mb.delete();
    sbq.delete();
    mpc   = pc;
    mskip = pc[2:0];
  endfunction

  function automatic void model_accept(input logic [63:0] w);
    for (int i = int'(mskip); i < 8; i++) mb.push_back(w[i*8 +: 8]);
    mskip = 3'd0;
    model_gen();
  endfunction

  // One clock: compare any issued instruction against the scoreboard, track
  // flush / word acceptance into the model, then step past the edge.
  task automatic cycle();
    exp_t e;
    if (rmode) bus.ins_ready_i = ($urandom_range(0, 3) != 0);
    acc = 1'b0;
    @(negedge clk);
    if (!rst && bus.ins_valid_o && bus.ins_ready_i) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got ins 0x%0h pc 0x%0h, required no issue", bus.ins_o, bus.ins_pc_o);
      end else begin
        e = sbq.pop_front();
        chk("ins_o", bus.ins_o, e.ins);
        chk("ins_len_o", 64'(bus.ins_len_o), 64'(e.len));
        chk("ins_pc_o", 64'(bus.ins_pc_o), 64'(e.pc));
        if (!first_seen) begin
          first_seen = 1'b1;
          first_ins  = bus.ins_o;
          first_len  = bus.ins_len_o;
        end
      end
    end
    if (bus.flush_i) model_flush(bus.flush_pc_i);
    else if (bus.fw_valid_i && bus.fw_ready_o) begin
      model_accept(bus.fw_i);
      acc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [AWID-1:0] pc);
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = pc;
    cycle();
    bus.flush_i    = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    int n = 0;
    bus.fw_i       = w;
    bus.fw_valid_i = 1'b1;
    do begin
      cycle();
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("fw_accept_timeout", 64'd0, 64'd1);
    bus.fw_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_pending", 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    rst            = 1'b1;
    bus.flush_i    = 1'b0;
    bus.flush_pc_i = '0;
    bus.fw_i       = '0;
    bus.fw_valid_i = 1'b0;
    bus.ins_ready_i = 1'b1;
    mpc   = '0;
    mskip = '0;
    for (int i = 0; i < 256; i++) lentab[i] = 4'(i >> 4);
    lentab[8'h01] = 4'd2;
    lentab[8'h03] = 4'd4;
    lentab[8'h07] = 4'd2;

    //           fpc           w0                     w1                     nw first_ins              len   final_pc
    vecs[0] = '{32'h0000_0100, 64'h0807060504030201, 64'h0,                1, 64'h0201,              4'd2, 32'h0000_0108};
    vecs[1] = '{32'h0000_0104, 64'hDDCCBB6A00000000, 64'h000000000000EEFF, 2, 64'h0000EEFFDDCCBB6A,  4'd6, 32'h0000_0110};
    vecs[2] = '{32'h0000_0200, 64'h0000000050505050, 64'h0,                1, 64'h5050,              4'd2, 32'h0000_0208};
    vecs[3] = '{32'h0000_03FA, 64'h8877665544332211, 64'h0,                1, 64'h4433,              4'd2, 32'h0000_0400};
    vecs[4] = '{32'h0000_0000, 64'h0102030405060788, 64'h0,                2, 64'h0102030405060788,  4'd8, 32'h0000_0010};
    vecs[5] = '{32'hFFFF_FFFC, 64'h2233444100000000, 64'h0,                1, 64'h22334441,          4'd4, 32'h0000_0000};

    // Reset state
    #3;
    chk("rst_ins_valid", 64'(bus.ins_valid_o), 64'd0);
    chk("rst_ins_o", bus.ins_o, 64'd0);
    chk("rst_ins_len", 64'(bus.ins_len_o), 64'd2);
    chk("rst_ins_pc", 64'(bus.ins_pc_o), 64'd0);
    chk("rst_fw_ready", 64'(bus.fw_ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven stream scenarios
    for (int v = 0; v < 6; v++) begin
      rmode = (v % 2) == 1;
      bus.ins_ready_i = 1'b1;
      first_seen = 1'b0;
      do_flush(vecs[v].fpc);
      send_word(vecs[v].w0);
      if (vecs[v].nw > 1) send_word(vecs[v].w1);
      drain();
      rmode = 1'b0;
      bus.ins_ready_i = 1'b1;
      repeat (2) cycle();
      chk("vec_first_seen", 64'(first_seen), 64'd1);
      chk("vec_first_ins", first_ins, vecs[v].first_ins);
      chk("vec_first_len", 64'(first_len), 64'(vecs[v].first_len));
      chk("vec_final_valid", 64'(bus.ins_valid_o), 64'd0);
      chk("vec_final_pc", 64'(bus.ins_pc_o), 64'(vecs[v].final_pc));
    end

    // Backpressure: fill to 16 bytes, third word held off
    bus.ins_ready_i = 1'b0;
    first_seen = 1'b1;
    do_flush('0);
    send_word(64'h1817161514131211);
    chk("bp_valid_8", 64'(bus.ins_valid_o), 64'd1);
    chk("bp_ready_8", 64'(bus.fw_ready_o), 64'd1);
    send_word(64'h2827262524232221);
    chk("bp_ready_16", 64'(bus.fw_ready_o), 64'd0);
    bus.fw_i       = 64'h3837363534333231;
    bus.fw_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_no_accept", 64'(acc), 64'd0);
      chk("bp_stable_ins", bus.ins_o, 64'h1211);
      chk("bp_stable_pc", 64'(bus.ins_pc_o), 64'd0);
      chk("bp_stable_valid", 64'(bus.ins_valid_o), 64'd1);
    end
    bus.ins_ready_i = 1'b1;
    send_word(64'h3837363534333231);
    drain();
    cycle();
    chk("bp_final_pc", 64'(bus.ins_pc_o), 64'h18);
    chk("bp_final_valid", 64'(bus.ins_valid_o), 64'd0);

    // Flush colliding with accept and issue
    bus.ins_ready_i = 1'b0;
    do_flush(32'h500);
    send_word(64'h1817161514131211);
    chk("fc_pre_valid", 64'(bus.ins_valid_o), 64'd1);
    bus.flush_i     = 1'b1;
    bus.flush_pc_i  = 32'h600;
    bus.fw_i        = 64'h2827262524232221;
    bus.fw_valid_i  = 1'b1;
    bus.ins_ready_i = 1'b1;
    #1;
    chk("fc_valid_during", 64'(bus.ins_valid_o), 64'd0);
    chk("fc_ready_during", 64'(bus.fw_ready_o), 64'd0);
    cycle();
    chk("fc_no_accept", 64'(acc), 64'd0);
    bus.flush_i    = 1'b0;
    bus.fw_valid_i = 1'b0;
    chk("fc_valid_after", 64'(bus.ins_valid_o), 64'd0);
    chk("fc_pc_after", 64'(bus.ins_pc_o), 64'h600);
    cycle();
    chk("fc_valid_later", 64'(bus.ins_valid_o), 64'd0);
    chk("fc_ready_later", 64'(bus.fw_ready_o), 64'd1);

    // Asynchronous reset mid-stream
    bus.ins_ready_i = 1'b0;
    do_flush(32'h700);
    send_word(64'h0807060504030201);
    chk("ar_pre_valid", 64'(bus.ins_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.ins_valid_o), 64'd0);
    chk("ar_pc", 64'(bus.ins_pc_o), 64'd0);
    chk("ar_ins", bus.ins_o, 64'd0);
    chk("ar_len", 64'(bus.ins_len_o), 64'd2);
    chk("ar_fw_ready", 64'(bus.fw_ready_o), 64'd1);
    model_flush('0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_post_ready", 64'(bus.fw_ready_o), 64'd1);
    chk("ar_post_valid", 64'(bus.ins_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
